// File: rtl/spart_echo_driver.sv
// SPART bus master: programs the baud divisor from br_cfg, then echoes
// every received byte back to the transmitter through a small FIFO.
module spart_echo_driver #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  br_cfg,
    output logic        iocs,
    output logic        iorw,
    output logic [1:0]  ioaddr,
    inout  wire  [7:0]  databus,
    input  logic        rda,
    input  logic        tbr,
    output logic        overflow,
    output logic [15:0] echo_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        INIT_LO,
        INIT_HI,
        IDLE,
        RD_RX,
        WR_TX,
        GAP
    } state_t;

    state_t          state_q;
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      cur_cfg_q, prog_q;
    logic            iocs_q, iorw_q;
    logic [1:0]      ioaddr_q;
    logic [7:0]      wdata_q;
    logic            ovf_q;
    logic [15:0]     echo_q;
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            full, empty, push;
    logic [7:0]      div_lo_d, div_hi_d;

    function automatic logic [7:0] div_byte(input logic [1:0] cfg, input logic hi);
        logic [15:0] d;
        unique case (cfg)
            2'b00:   d = 16'h0515;
            2'b01:   d = 16'h028A;
            2'b10:   d = 16'h0145;
            default: d = 16'h00A2;
        endcase
        return hi ? d[15:8] : d[7:0];
    endfunction

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign push     = (state_q == RD_RX) && !full;
    assign div_lo_d = div_byte(sync2_q, 1'b0);
    assign div_hi_d = div_byte(prog_q, 1'b1);

    // Storage has no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= databus;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= INIT_LO;
            sync1_q   <= 2'b00;
            sync2_q   <= 2'b00;
            cur_cfg_q <= 2'b00;
            prog_q    <= 2'b00;
            iocs_q    <= 1'b0;
            iorw_q    <= 1'b1;
            ioaddr_q  <= 2'b00;
            wdata_q   <= 8'h00;
            ovf_q     <= 1'b0;
            echo_q    <= 16'h0000;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            sync1_q <= br_cfg;
            sync2_q <= sync1_q;
            unique case (state_q)
                INIT_LO: begin
                    iocs_q   <= 1'b1;
                    iorw_q   <= 1'b0;
                    ioaddr_q <= 2'b10;
                    wdata_q  <= div_lo_d;
                    prog_q   <= sync2_q;
                    state_q  <= INIT_HI;
                end
                INIT_HI: begin
                    iocs_q    <= 1'b1;
                    iorw_q    <= 1'b0;
                    ioaddr_q  <= 2'b11;
                    wdata_q   <= div_hi_d;
                    cur_cfg_q <= prog_q;
                    state_q   <= GAP;
                end
                IDLE: begin
                    if (sync2_q != cur_cfg_q) begin
                        iocs_q  <= 1'b0;
                        state_q <= INIT_LO;
                    end else if (rda) begin
                        iocs_q   <= 1'b1;
                        iorw_q   <= 1'b1;
                        ioaddr_q <= 2'b00;
                        state_q  <= RD_RX;
                    end else if (tbr && !empty) begin
                        iocs_q   <= 1'b1;
                        iorw_q   <= 1'b0;
                        ioaddr_q <= 2'b00;
                        wdata_q  <= mem_q[rd_ptr_q];
                        state_q  <= WR_TX;
                    end else begin
                        iocs_q <= 1'b0;
                    end
                end
                RD_RX: begin
                    iocs_q <= 1'b0;
                    iorw_q <= 1'b1;
                    if (full) begin
                        ovf_q <= 1'b1;
                    end else begin
                        wr_ptr_q <= wr_ptr_q + AW'(1);
                        count_q  <= count_q + CW'(1);
                    end
                    state_q <= GAP;
                end
                WR_TX: begin
                    iocs_q   <= 1'b0;
                    iorw_q   <= 1'b1;
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                    count_q  <= count_q - CW'(1);
                    echo_q   <= echo_q + 16'd1;
                    state_q  <= GAP;
                end
                GAP: begin
                    iocs_q  <= 1'b0;
                    iorw_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    iocs_q  <= 1'b0;
                    iorw_q  <= 1'b1;
                    state_q <= INIT_LO;
                end
            endcase
        end
    end

    assign iocs       = iocs_q;
    assign iorw       = iorw_q;
    assign ioaddr     = ioaddr_q;
    assign databus    = (iocs_q && !iorw_q) ? wdata_q : 8'hzz;
    assign overflow   = ovf_q;
    assign echo_count = echo_q;

endmodule
